// File: rtl/rice_bus_arbiter.sv
// N-master to 1-slave rice bus arbiter: zero-latency combinational request/response muxing.
// Backpressure: requests stall on slave not-ready or full ID FIFO (grant held); responses stall on head master not-ready.

module rice_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop_vld,
  output logic [WIDTH-1:0] head_dat,
  output logic             empty,
  output logic             full
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_vld) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_vld) begin
        wr_ptr <= wrap_inc(wr_ptr);
      end
      if (pop_vld) begin
        rd_ptr <= wrap_inc(rd_ptr);
      end
      case ({push_vld, pop_vld})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module rice_bus_arbiter #(
  parameter int MASTERS         = 2,
  parameter int ADDRESS_WIDTH   = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2,
  parameter int ROUND_ROBIN     = 1
) (
  input  logic                                    i_clk,
  input  logic                                    i_rst,
  input  logic [MASTERS-1:0]                      i_request_valid,
  output logic [MASTERS-1:0]                      o_request_ready,
  input  logic [MASTERS-1:0][ADDRESS_WIDTH-1:0]   i_address,
  input  logic [MASTERS-1:0]                      i_write,
  input  logic [MASTERS-1:0][DATA_WIDTH-1:0]      i_write_data,
  input  logic [MASTERS-1:0][DATA_WIDTH/8-1:0]    i_strobe,
  output logic                                    o_request_valid,
  input  logic                                    i_request_ready,
  output logic [ADDRESS_WIDTH-1:0]                o_address,
  output logic                                    o_write,
  output logic [DATA_WIDTH-1:0]                   o_write_data,
  output logic [DATA_WIDTH/8-1:0]                 o_strobe,
  input  logic                                    i_response_valid,
  output logic                                    o_response_ready,
  input  logic [DATA_WIDTH-1:0]                   i_response_data,
  input  logic                                    i_response_error,
  output logic [MASTERS-1:0]                      o_response_valid,
  input  logic [MASTERS-1:0]                      i_response_ready,
  output logic [DATA_WIDTH-1:0]                   o_response_data,
  output logic                                    o_response_error
);
  localparam int IDX_W  = $clog2(MASTERS);
  localparam int STRB_W = DATA_WIDTH / 8;

  typedef struct packed {
    logic [ADDRESS_WIDTH-1:0] addr;
    logic                     write;
    logic [DATA_WIDTH-1:0]    wdat;
    logic [STRB_W-1:0]        strb;
  } req_t;

  req_t             reqs [MASTERS];
  req_t             grant_req;
  logic [IDX_W-1:0] rr_ptr;
  logic             lock_vld;
  logic [IDX_W-1:0] lock_idx;
  logic [IDX_W-1:0] arb_idx;
  logic             arb_found;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_vld;
  logic [IDX_W:0]   cand_sum;
  logic [IDX_W-1:0] cand;
  logic [IDX_W-1:0] head_idx;
  logic             fifo_empty;
  logic             fifo_full;
  logic             req_hs;
  logic             rsp_hs;

  always_comb begin
    for (int m = 0; m < MASTERS; m++) begin
      reqs[m].addr  = i_address[m];
      reqs[m].write = i_write[m];
      reqs[m].wdat  = i_write_data[m];
      reqs[m].strb  = i_strobe[m];
    end
  end

  // rr_ptr stays at 0 in fixed-priority mode, so the same scan yields lowest-index-wins.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand_sum  = '0;
    cand      = '0;
    for (int i = 0; i < MASTERS; i++) begin
      cand_sum = {1'b0, rr_ptr} + (IDX_W + 1)'(i);
      if (cand_sum >= (IDX_W + 1)'(MASTERS)) begin
        cand_sum = cand_sum - (IDX_W + 1)'(MASTERS);
      end
      cand = cand_sum[IDX_W-1:0];
      if (!arb_found && i_request_valid[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  assign grant_idx = lock_vld ? lock_idx : arb_idx;
  assign grant_vld = lock_vld | arb_found;
  assign grant_req = reqs[grant_idx];

  assign o_request_valid = !i_rst && grant_vld && i_request_valid[grant_idx] && !fifo_full;
  assign o_address       = grant_req.addr;
  assign o_write         = grant_req.write;
  assign o_write_data    = grant_req.wdat;
  assign o_strobe        = grant_req.strb;

  always_comb begin
    o_request_ready = '0;
    if (!i_rst && grant_vld && !fifo_full) begin
      o_request_ready[grant_idx] = i_request_ready;
    end
  end

  assign req_hs = o_request_valid & i_request_ready;

  always_comb begin
    o_response_valid = '0;
    if (!i_rst && !fifo_empty) begin
      o_response_valid[head_idx] = i_response_valid;
    end
  end

  assign o_response_ready = !i_rst && !fifo_empty && i_response_ready[head_idx];
  assign o_response_data  = i_response_data;
  assign o_response_error = i_response_error;
  assign rsp_hs           = i_response_valid & o_response_ready;

  // Full blocks requests even on a same-cycle pop, keeping response->request paths apart.
  rice_fifo #(
    .WIDTH (IDX_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk      (i_clk),
    .rst      (i_rst),
    .push_vld (req_hs),
    .push_dat (grant_idx),
    .pop_vld  (rsp_hs),
    .head_dat (head_idx),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      lock_vld <= 1'b0;
      lock_idx <= '0;
      rr_ptr   <= '0;
    end else begin
      if (req_hs) begin
        lock_vld <= 1'b0;
        if (ROUND_ROBIN != 0) begin
          rr_ptr <= (grant_idx == IDX_W'(MASTERS - 1)) ? '0 : grant_idx + 1'b1;
        end
      end else if (o_request_valid) begin
        lock_vld <= 1'b1;
        lock_idx <= grant_idx;
      end
    end
  end

  a_rsp_when_empty: assert property (@(posedge i_clk) disable iff (i_rst)
    !(i_response_valid && fifo_empty));

  a_locked_master_holds: assert property (@(posedge i_clk) disable iff (i_rst)
    lock_vld |-> i_request_valid[lock_idx]);
endmodule

// File: tb/tb_rice_bus_arbiter.sv
// Bench: two arbiters (round-robin and fixed-priority, 3 masters, 2 outstanding) against a queue model.
module tb_rice_bus_arbiter;
  localparam int M  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int MO = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [M-1:0]         m_vld     [2];
  logic [M-1:0][AW-1:0] m_addr    [2];
  logic [M-1:0]         m_wr      [2];
  logic [M-1:0][DW-1:0] m_wdat    [2];
  logic [M-1:0][SW-1:0] m_strb    [2];
  logic                 s_rdy     [2];
  logic                 s_rsp_vld [2];
  logic [DW-1:0]        s_rsp_dat [2];
  logic                 s_rsp_err [2];
  logic [M-1:0]         m_rsp_rdy [2];

  logic [M-1:0]  d_req_rdy [2];
  logic          d_req_vld [2];
  logic [AW-1:0] d_addr    [2];
  logic          d_wr      [2];
  logic [DW-1:0] d_wdat    [2];
  logic [SW-1:0] d_strb    [2];
  logic          d_rsp_rdy [2];
  logic [M-1:0]  d_rsp_vld [2];
  logic [DW-1:0] d_rsp_dat [2];
  logic          d_rsp_err [2];

  rice_bus_arbiter #(.MASTERS(M), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW),
                     .MAX_OUTSTANDING(MO), .ROUND_ROBIN(1)) u_rr (
    .i_clk(clk), .i_rst(rst),
    .i_request_valid(m_vld[0]), .o_request_ready(d_req_rdy[0]),
    .i_address(m_addr[0]), .i_write(m_wr[0]), .i_write_data(m_wdat[0]), .i_strobe(m_strb[0]),
    .o_request_valid(d_req_vld[0]), .i_request_ready(s_rdy[0]),
    .o_address(d_addr[0]), .o_write(d_wr[0]), .o_write_data(d_wdat[0]), .o_strobe(d_strb[0]),
    .i_response_valid(s_rsp_vld[0]), .o_response_ready(d_rsp_rdy[0]),
    .i_response_data(s_rsp_dat[0]), .i_response_error(s_rsp_err[0]),
    .o_response_valid(d_rsp_vld[0]), .i_response_ready(m_rsp_rdy[0]),
    .o_response_data(d_rsp_dat[0]), .o_response_error(d_rsp_err[0])
  );

  rice_bus_arbiter #(.MASTERS(M), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW),
                     .MAX_OUTSTANDING(MO), .ROUND_ROBIN(0)) u_fp (
    .i_clk(clk), .i_rst(rst),
    .i_request_valid(m_vld[1]), .o_request_ready(d_req_rdy[1]),
    .i_address(m_addr[1]), .i_write(m_wr[1]), .i_write_data(m_wdat[1]), .i_strobe(m_strb[1]),
    .o_request_valid(d_req_vld[1]), .i_request_ready(s_rdy[1]),
    .o_address(d_addr[1]), .o_write(d_wr[1]), .o_write_data(d_wdat[1]), .o_strobe(d_strb[1]),
    .i_response_valid(s_rsp_vld[1]), .o_response_ready(d_rsp_rdy[1]),
    .i_response_data(s_rsp_dat[1]), .i_response_error(s_rsp_err[1]),
    .o_response_valid(d_rsp_vld[1]), .i_response_ready(m_rsp_rdy[1]),
    .o_response_data(d_rsp_dat[1]), .o_response_error(d_rsp_err[1])
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model state per instance: outstanding master queue, locked master (-1 none), rr pointer.
  int q      [2][8];
  int qn     [2];
  int lock_m [2];
  int ptr    [2];
  int glog   [2][64];
  logic [AW-1:0] alog [2][64];
  int gn     [2];
  int rlog   [2][64];
  int rn     [2];
  bit auto_rsp [2];
  int rsp_ctr = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step(input int k);
    int g, h, c;
    bit found, full, exp_rv, exp_srr, hs_req, hs_rsp;
    logic [M-1:0] exp_rr, exp_sv;
    full  = (qn[k] >= MO);
    found = 1'b0;
    g     = 0;
    if (lock_m[k] >= 0) begin
      g = lock_m[k];
      found = 1'b1;
    end else begin
      for (int i = 0; i < M; i++) begin
        c = (k == 0) ? (ptr[k] + i) % M : i;
        if (!found && m_vld[k][c]) begin
          g = c;
          found = 1'b1;
        end
      end
    end
    exp_rv = found && m_vld[k][g] && !full;
    exp_rr = '0;
    if (found && s_rdy[k] && !full) exp_rr[g] = 1'b1;
    chk($sformatf("k%0d req_vld", k), 64'(d_req_vld[k]), 64'(exp_rv));
    chk($sformatf("k%0d req_rdy", k), 64'(d_req_rdy[k]), 64'(exp_rr));
    if (exp_rv) begin
      chk($sformatf("k%0d addr", k), 64'(d_addr[k]), 64'(m_addr[k][g]));
      chk($sformatf("k%0d write", k), 64'(d_wr[k]), 64'(m_wr[k][g]));
      chk($sformatf("k%0d wdata", k), 64'(d_wdat[k]), 64'(m_wdat[k][g]));
      chk($sformatf("k%0d strobe", k), 64'(d_strb[k]), 64'(m_strb[k][g]));
    end
    exp_sv  = '0;
    exp_srr = 1'b0;
    h       = 0;
    if (qn[k] > 0) begin
      h = q[k][0];
      exp_sv[h] = s_rsp_vld[k];
      exp_srr   = m_rsp_rdy[k][h];
    end
    chk($sformatf("k%0d rsp_vld", k), 64'(d_rsp_vld[k]), 64'(exp_sv));
    chk($sformatf("k%0d rsp_rdy", k), 64'(d_rsp_rdy[k]), 64'(exp_srr));
    if (qn[k] > 0 && s_rsp_vld[k]) begin
      chk($sformatf("k%0d rsp_data", k), 64'(d_rsp_dat[k]), 64'(s_rsp_dat[k]));
      chk($sformatf("k%0d rsp_err", k), 64'(d_rsp_err[k]), 64'(s_rsp_err[k]));
    end
    hs_req = exp_rv && s_rdy[k];
    hs_rsp = (qn[k] > 0) && s_rsp_vld[k] && exp_srr;
    if (hs_rsp) begin
      if (rn[k] < 64) rlog[k][rn[k]] = h;
      rn[k]++;
      for (int j = 0; j < 7; j++) q[k][j] = q[k][j+1];
      qn[k]--;
    end
    if (hs_req) begin
      q[k][qn[k]] = g;
      qn[k]++;
      if (gn[k] < 64) begin
        glog[k][gn[k]] = g;
        alog[k][gn[k]] = m_addr[k][g];
      end
      gn[k]++;
      if (k == 0) ptr[k] = (g + 1) % M;
      lock_m[k] = -1;
    end else if (exp_rv) begin
      lock_m[k] = g;
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        chk($sformatf("k%0d rst req_vld", k), 64'(d_req_vld[k]), 64'h0);
        chk($sformatf("k%0d rst req_rdy", k), 64'(d_req_rdy[k]), 64'h0);
        chk($sformatf("k%0d rst rsp_vld", k), 64'(d_rsp_vld[k]), 64'h0);
        chk($sformatf("k%0d rst rsp_rdy", k), 64'(d_rsp_rdy[k]), 64'h0);
        qn[k]     = 0;
        lock_m[k] = -1;
        ptr[k]    = 0;
      end else begin
        model_step(k);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      if (auto_rsp[k]) begin
        s_rsp_vld[k] = (qn[k] > 0);
        s_rsp_dat[k] = 32'hC0DE_0000 + 32'(rsp_ctr);
        s_rsp_err[k] = 1'b0;
        rsp_ctr++;
      end
    end
  endtask

  int exp_fair [6] = '{0, 1, 2, 0, 1, 2};
  int exp_fp   [5] = '{0, 0, 0, 0, 1};
  int g0, r0;

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_vld[k] = '0; s_rdy[k] = 1'b0; s_rsp_vld[k] = 1'b0; s_rsp_dat[k] = '0;
      s_rsp_err[k] = 1'b0; m_rsp_rdy[k] = '0; auto_rsp[k] = 1'b0;
      gn[k] = 0; rn[k] = 0; qn[k] = 0; lock_m[k] = -1; ptr[k] = 0;
      for (int i = 0; i < M; i++) begin
        m_addr[k][i] = 32'h1000 + 32'(16 * i);
        m_wr[k][i]   = (i % 2 == 1);
        m_wdat[k][i] = 32'hA000_0000 + 32'(i);
        m_strb[k][i] = 4'hF >> i;
      end
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("post-reset req_vld", 64'(d_req_vld[0]), 64'h0);
    chk("post-reset rsp_vld", 64'(d_rsp_vld[0]), 64'h0);

    // Round-robin fairness: all three masters valid, one-cycle responses.
    auto_rsp[0] = 1'b1; s_rdy[0] = 1'b1; m_rsp_rdy[0] = 3'b111; m_vld[0] = 3'b111;
    g0 = gn[0]; r0 = rn[0];
    repeat (6) tick();
    m_vld[0] = '0;
    repeat (3) tick();
    chk("fair grant count", 64'(gn[0] - g0), 64'd6);
    chk("fair response count", 64'(rn[0] - r0), 64'd6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("fair grant %0d", i), 64'(glog[0][g0+i]), 64'(exp_fair[i]));
      chk($sformatf("fair route %0d", i), 64'(rlog[0][r0+i]), 64'(exp_fair[i]));
    end

    // Fixed priority on the second instance.
    auto_rsp[1] = 1'b1; s_rdy[1] = 1'b1; m_rsp_rdy[1] = 3'b111; m_vld[1] = 3'b011;
    g0 = gn[1];
    repeat (4) tick();
    m_vld[1] = 3'b010;
    tick();
    m_vld[1] = '0;
    repeat (2) tick();
    chk("fp grant count", 64'(gn[1] - g0), 64'd5);
    for (int i = 0; i < 5; i++)
      chk($sformatf("fp grant %0d", i), 64'(glog[1][g0+i]), 64'(exp_fp[i]));

    // Lock on stall: master 1 stalled three cycles, master 0 joins in cycle 2.
    s_rdy[0] = 1'b0; m_addr[0][1] = 32'h100; m_addr[0][0] = 32'h200; m_vld[0] = 3'b010;
    g0 = gn[0];
    for (int c = 1; c <= 3; c++) begin
      #1;
      chk($sformatf("lock addr c%0d", c), 64'(d_addr[0]), 64'h100);
      chk($sformatf("lock vld c%0d", c), 64'(d_req_vld[0]), 64'h1);
      chk($sformatf("lock rdy c%0d", c), 64'(d_req_rdy[0]), 64'h0);
      tick();
      m_vld[0] = 3'b011;
    end
    s_rdy[0] = 1'b1;
    #1 chk("lock handshake rdy", 64'(d_req_rdy[0]), 64'h2);
    tick();
    m_vld[0] = 3'b001;
    #1 chk("after lock rdy", 64'(d_req_rdy[0]), 64'h1);
    chk("after lock addr", 64'(d_addr[0]), 64'h200);
    tick();
    m_vld[0] = '0;
    repeat (3) tick();
    chk("lock grant a", 64'(glog[0][g0]), 64'd1);
    chk("lock grant b", 64'(glog[0][g0+1]), 64'd0);
    chk("lock addr log", 64'(alog[0][g0]), 64'h100);

    // FIFO full: two accepted, third blocked even while a response pops.
    auto_rsp[0] = 1'b0; s_rsp_vld[0] = 1'b0; m_rsp_rdy[0] = '0; s_rdy[0] = 1'b1;
    m_addr[0][0] = 32'h300; m_addr[0][1] = 32'h310; m_addr[0][2] = 32'h320;
    m_vld[0] = 3'b111;
    #1 chk("full first rdy", 64'(d_req_rdy[0]), 64'h2);
    tick();
    m_vld[0] = 3'b101;
    #1 chk("full second rdy", 64'(d_req_rdy[0]), 64'h4);
    tick();
    m_vld[0] = 3'b001; s_rsp_vld[0] = 1'b1; s_rsp_dat[0] = 32'h11; m_rsp_rdy[0] = 3'b010;
    #1;
    chk("full blocked vld", 64'(d_req_vld[0]), 64'h0);
    chk("full blocked rdy", 64'(d_req_rdy[0]), 64'h0);
    chk("full rsp route", 64'(d_rsp_vld[0]), 64'h2);
    chk("full rsp rdy", 64'(d_rsp_rdy[0]), 64'h1);
    tick();
    s_rsp_vld[0] = 1'b0; m_rsp_rdy[0] = '0;
    #1;
    chk("full released vld", 64'(d_req_vld[0]), 64'h1);
    chk("full released addr", 64'(d_addr[0]), 64'h300);
    tick();
    m_vld[0] = '0;

    // Response backpressure with error; outstanding order is master 2 then master 0.
    s_rsp_vld[0] = 1'b1; s_rsp_dat[0] = 32'hDEAD_BEEF; s_rsp_err[0] = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk($sformatf("bp rsp_vld c%0d", c), 64'(d_rsp_vld[0]), 64'h4);
      chk($sformatf("bp rsp_rdy c%0d", c), 64'(d_rsp_rdy[0]), 64'h0);
      tick();
    end
    m_rsp_rdy[0] = 3'b100;
    #1;
    chk("bp hs rdy", 64'(d_rsp_rdy[0]), 64'h1);
    chk("bp hs data", 64'(d_rsp_dat[0]), 64'hDEAD_BEEF);
    chk("bp hs err", 64'(d_rsp_err[0]), 64'h1);
    tick();
    s_rsp_dat[0] = 32'h5; s_rsp_err[0] = 1'b0; m_rsp_rdy[0] = '0; m_vld[0] = 3'b010;
    #1;
    chk("bp single pop head", 64'(d_rsp_vld[0]), 64'h1);
    chk("bp next rdy", 64'(d_rsp_rdy[0]), 64'h0);
    tick();
    m_vld[0] = '0;

    // Reset with two responses pending.
    m_vld[0] = 3'b111; m_rsp_rdy[0] = 3'b111;
    #1 chk("pre-reset rsp_vld", 64'(d_rsp_vld[0]), 64'h1);
    #1 rst = 1'b1;
    #1;
    chk("async rst req_vld", 64'(d_req_vld[0]), 64'h0);
    chk("async rst req_rdy", 64'(d_req_rdy[0]), 64'h0);
    chk("async rst rsp_vld", 64'(d_rsp_vld[0]), 64'h0);
    chk("async rst rsp_rdy", 64'(d_rsp_rdy[0]), 64'h0);
    s_rsp_vld[0] = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    chk("post-rst winner", 64'(d_req_rdy[0]), 64'h1);
    chk("post-rst vld", 64'(d_req_vld[0]), 64'h1);
    chk("post-rst fifo empty", 64'(d_rsp_vld[0]), 64'h0);
    tick();
    #1 chk("post-rst second", 64'(d_req_rdy[0]), 64'h2);
    tick();
    m_vld[0] = '0;
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
